// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline control unit.
//  - stall bus width and per-stage stop/no-stop encodings
//  - stall patterns for each request source
//  - exception codes and the redirect default word
//  - FSM state encoding
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 4;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Bit order: [0]=PC [1]=IF/ID [2]=ID/EXE [3]=EXE/MEM
  localparam logic [STALL_W-1:0] STALL_NONE = {NOSTOP, NOSTOP, NOSTOP, NOSTOP};
  localparam logic [STALL_W-1:0] STALL_ID   = {NOSTOP, NOSTOP, STOP,   STOP};
  localparam logic [STALL_W-1:0] STALL_EXE  = {NOSTOP, STOP,   STOP,   STOP};
  localparam logic [STALL_W-1:0] STALL_MEM  = {STOP,   STOP,   STOP,   STOP};

  localparam logic [4:0]  EXC_ERET  = 5'h0d;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StBlank = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_mem_wait_timer.sv
// Memory wait watchdog.
//  clk       in  clock
//  rst_n     in  synchronous reset, active-low
//  count_en  in  a qualifying memory-wait cycle is in progress
//  timeout   out registered one-cycle pulse after MEM_TIMEOUT consecutive wait cycles
module pipe_ctrl_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  output logic timeout
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] wait_cnt_q;
  logic            timeout_q;

  // Any break in the wait (request dropped, flush, blank cycle) restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (!count_en) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q == CntMax) begin
        wait_cnt_q <= '0;
        timeout_q  <= 1'b1;
      end else begin
        wait_cnt_q <= wait_cnt_q + CntW'(1);
      end
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: arbitrates ID/EXE/MEM stall requests, converts MEM
// exceptions/ERET into a flush plus redirect PC, times out stuck memory waits
// and counts stalled cycles.
//  cpu_clk_50M   in  clock
//  cpu_rst_n     in  synchronous reset, active-low
//  stallreq_id   in  load-use hazard in ID
//  stallreq_exe  in  multi-cycle op busy in EXE
//  stallreq_mem  in  data bus wait in MEM
//  excp_req      in  exception/ERET committed in MEM
//  excp_type     in  exception code
//  cp0_epc       in  EPC from CP0
//  stall         out [0]=PC [1]=IF/ID [2]=ID/EXE [3]=EXE/MEM
//  flush         out clear all inter-stage registers at next edge
//  flush_pc      out redirect target, valid while flush=1
//  bus_timeout   out one-cycle memory wait timeout pulse
//  stall_cycles  out count of cycles with a nonzero stall
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY   = 32'h0000_0100,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  input  logic               stallreq_id,
  input  logic               stallreq_exe,
  input  logic               stallreq_mem,
  input  logic               excp_req,
  input  logic [4:0]         excp_type,
  input  logic [31:0]        cp0_epc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        flush_pc,
  output logic               bus_timeout,
  output logic [CNT_W-1:0]   stall_cycles
);

  state_e           state_q;
  logic [CNT_W-1:0] stall_cycles_q;
  logic             timer_en;

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun:   if (excp_req) state_q <= StBlank;
        StBlank: state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end

  // Requests seen in BLANK come from instructions killed by the flush, so they are dropped.
  always_comb begin
    stall    = STALL_NONE;
    flush    = 1'b0;
    flush_pc = ZERO_WORD;
    if (cpu_rst_n && state_q == StRun) begin
      if (excp_req) begin
        flush    = 1'b1;
        flush_pc = (excp_type == EXC_ERET) ? cp0_epc : EXC_ENTRY;
      end else if (stallreq_mem) begin
        stall = STALL_MEM;
      end else if (stallreq_exe) begin
        stall = STALL_EXE;
      end else if (stallreq_id) begin
        stall = STALL_ID;
      end
    end
  end

  assign timer_en = (state_q == StRun) && stallreq_mem && !excp_req;

  pipe_ctrl_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (cpu_clk_50M),
    .rst_n    (cpu_rst_n),
    .count_en (timer_en),
    .timeout  (bus_timeout)
  );

  // Free-running perf counter; wraps naturally and survives flushes.
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      stall_cycles_q <= '0;
    end else if (stall != STALL_NONE) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
